// File: rtl/ysyx_22041412_sram_arb_if.sv
// rtl/ysyx_22041412_sram_arb_if.sv - request/response port between one memory master and the SRAM arbiter
interface ysyx_22041412_sram_arb_if #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 64
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_we;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [DATA_WIDTH-1:0] req_wdata;
   logic                  resp_valid;
   logic [DATA_WIDTH-1:0] resp_rdata;

   modport master (
      output req_valid, req_we, req_addr, req_wdata,
      input  req_ready, resp_valid, resp_rdata
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata,
      output req_ready, resp_valid, resp_rdata
   );
endinterface

// File: rtl/ysyx_22041412_sram_arb.sv
// rtl/ysyx_22041412_sram_arb.sv - two-master round-robin arbiter owning the scratch SRAM enables
module ysyx_22041412_sram_arb #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   ysyx_22041412_sram_arb_if.slave m0,
   ysyx_22041412_sram_arb_if.slave m1,
   output logic                  sram_read_en,
   output logic                  sram_wead_en,
   output logic [ADDR_WIDTH-1:0] sram_addr_r,
   output logic [ADDR_WIDTH-1:0] sram_addr_w,
   output logic [DATA_WIDTH-1:0] sram_data_w,
   input  logic [DATA_WIDTH-1:0] sram_data_r
);

   logic                  last_grant;
   logic [1:0]            resp_pend;
   logic                  resp_is_rd;

   logic                  gnt_vld;
   logic                  gnt_idx;
   logic                  issue;
   logic                  sel_we;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0] sel_wdata;

   // On conflict the master that did not win last time gets the slot.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = 1'b0;
      case ({m1.req_valid, m0.req_valid})
         2'b11: begin gnt_vld = 1'b1; gnt_idx = ~last_grant; end
         2'b01: begin gnt_vld = 1'b1; gnt_idx = 1'b0;        end
         2'b10: begin gnt_vld = 1'b1; gnt_idx = 1'b1;        end
         default: begin gnt_vld = 1'b0; gnt_idx = 1'b0;      end
      endcase
   end

   assign issue = gnt_vld & ~rst;

   // With no grant gnt_idx is 0, so idle address/data follow m0.
   assign sel_we    = gnt_idx ? m1.req_we    : m0.req_we;
   assign sel_addr  = gnt_idx ? m1.req_addr  : m0.req_addr;
   assign sel_wdata = gnt_idx ? m1.req_wdata : m0.req_wdata;

   assign m0.req_ready = issue & ~gnt_idx;
   assign m1.req_ready = issue &  gnt_idx;

   assign sram_wead_en = issue &  sel_we;
   assign sram_read_en = issue & ~sel_we;
   assign sram_addr_r  = sel_addr;
   assign sram_addr_w  = sel_addr;
   assign sram_data_w  = sel_wdata;

   assign m0.resp_valid = resp_pend[0];
   assign m1.resp_valid = resp_pend[1];
   assign m0.resp_rdata = resp_is_rd ? sram_data_r : '0;
   assign m1.resp_rdata = resp_is_rd ? sram_data_r : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant <= 1'b1;
         resp_pend  <= 2'b00;
         resp_is_rd <= 1'b0;
      end else if (issue) begin
         last_grant <= gnt_idx;
         resp_pend  <= gnt_idx ? 2'b10 : 2'b01;
         resp_is_rd <= ~sel_we;
      end else begin
         resp_pend  <= 2'b00;
      end
   end

endmodule

// File: tb/tb_ysyx_22041412_sram_arb.sv
// tb/tb_ysyx_22041412_sram_arb.sv - directed checks of the scratch SRAM arbiter
module tb_ysyx_22041412_sram_arb;
   localparam int AW = 12;
   localparam int DW = 64;
   localparam logic [63:0] WD = 64'h1122334455667788;

   logic          clk = 1'b0;
   logic          rst;
   logic          sram_read_en, sram_wead_en;
   logic [AW-1:0] sram_addr_r, sram_addr_w;
   logic [DW-1:0] sram_data_w;
   logic [DW-1:0] rd_q;
   logic [DW-1:0] mem [0:4095];
   logic          preloaded = 1'b0;

   int n_checks = 0;
   int n_errors = 0;

   ysyx_22041412_sram_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m0_if ();
   ysyx_22041412_sram_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m1_if ();

   ysyx_22041412_sram_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk          (clk),
      .rst          (rst),
      .m0           (m0_if.slave),
      .m1           (m1_if.slave),
      .sram_read_en (sram_read_en),
      .sram_wead_en (sram_wead_en),
      .sram_addr_r  (sram_addr_r),
      .sram_addr_w  (sram_addr_w),
      .sram_data_w  (sram_data_w),
      .sram_data_r  (rd_q)
   );

   always #5 clk = ~clk;

   // Behavioural scratch SRAM with registered read; contents seeded during the first reset edge.
   always @(posedge clk) begin
      if (rst && !preloaded) begin
         mem[12'h020] <= 64'hA;
         mem[12'h030] <= 64'hB;
         mem[12'h040] <= 64'h5;
         preloaded    <= 1'b1;
      end else begin
         if (sram_wead_en) mem[sram_addr_w] <= sram_data_w;
         if (sram_read_en) rd_q <= mem[sram_addr_r];
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic drv0(input logic v, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      m0_if.req_valid = v;
      m0_if.req_we    = we;
      m0_if.req_addr  = a;
      m0_if.req_wdata = d;
   endtask

   task automatic drv1(input logic v, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      m1_if.req_valid = v;
      m1_if.req_we    = we;
      m1_if.req_addr  = a;
      m1_if.req_wdata = d;
   endtask

   initial begin
      rst = 1'b1;
      drv0(1'b1, 1'b0, 12'h020, '0);
      drv1(1'b1, 1'b0, 12'h030, '0);

      // reset holds everything quiet even with both masters requesting
      repeat (2) @(negedge clk);
      #1;
      check("rst_m0_ready", m0_if.req_ready, 0);
      check("rst_m1_ready", m1_if.req_ready, 0);
      check("rst_rd_en", sram_read_en, 0);
      check("rst_wr_en", sram_wead_en, 0);
      check("rst_m0_resp", m0_if.resp_valid, 0);
      check("rst_m1_resp", m1_if.resp_valid, 0);

      @(negedge clk);
      rst = 1'b0;
      #1;
      check("first_m0_ready", m0_if.req_ready, 1);
      check("first_m1_ready", m1_if.req_ready, 0);
      check("first_rd_en", sram_read_en, 1);
      check("first_addr_r", sram_addr_r, 12'h020);
      @(posedge clk); #1;
      check("first_m0_resp", m0_if.resp_valid, 1);
      check("first_rdata", m0_if.resp_rdata, 64'hA);

      // single write then read-back by m0
      @(negedge clk);
      drv1(1'b0, 1'b0, 12'h000, '0);
      drv0(1'b1, 1'b1, 12'h010, WD);
      #1;
      check("wr_m0_ready", m0_if.req_ready, 1);
      check("wr_en", sram_wead_en, 1);
      check("wr_rd_en", sram_read_en, 0);
      check("wr_addr", sram_addr_w, 12'h010);
      check("wr_data", sram_data_w, WD);
      @(posedge clk); #1;
      check("wr_m0_resp", m0_if.resp_valid, 1);
      check("wr_m1_resp", m1_if.resp_valid, 0);
      @(negedge clk);
      drv0(1'b1, 1'b0, 12'h010, '0);
      #1;
      check("rd_en", sram_read_en, 1);
      @(posedge clk); #1;
      check("rd_m0_resp", m0_if.resp_valid, 1);
      check("rd_rdata", m0_if.resp_rdata, WD);
      check("rd_m1_resp", m1_if.resp_valid, 0);
      @(negedge clk);
      drv0(1'b0, 1'b0, 12'h000, '0);
      @(posedge clk); #1;
      check("idle_m0_resp", m0_if.resp_valid, 0);

      // contention after a fresh reset: strict alternation starting at m0
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      drv0(1'b1, 1'b0, 12'h020, '0);
      drv1(1'b1, 1'b0, 12'h030, '0);
      for (int i = 0; i < 6; i++) begin
         #1;
         check($sformatf("rr_m0_ready_%0d", i), m0_if.req_ready, (i % 2 == 0));
         check($sformatf("rr_m1_ready_%0d", i), m1_if.req_ready, (i % 2 == 1));
         @(posedge clk); #1;
         check($sformatf("rr_m0_resp_%0d", i), m0_if.resp_valid, (i % 2 == 0));
         check($sformatf("rr_m1_resp_%0d", i), m1_if.resp_valid, (i % 2 == 1));
         check($sformatf("rr_rdata_%0d", i), m0_if.resp_rdata, (i % 2 == 0) ? 64'hA : 64'hB);
         @(negedge clk);
      end

      // read-before-write on 0x040
      drv1(1'b0, 1'b0, 12'h000, '0);
      drv0(1'b1, 1'b0, 12'h040, '0);
      #1;
      check("rbw_m0_ready", m0_if.req_ready, 1);
      @(posedge clk); #1;
      check("rbw_rdata", m0_if.resp_rdata, 64'h5);
      @(negedge clk);
      drv0(1'b0, 1'b0, 12'h000, '0);
      drv1(1'b1, 1'b1, 12'h040, 64'h9);
      #1;
      check("rbw_old_rdata", m0_if.resp_rdata, 64'h5);
      check("rbw_wr_en", sram_wead_en, 1);
      @(negedge clk);
      drv1(1'b0, 1'b0, 12'h000, '0);
      drv0(1'b1, 1'b0, 12'h040, '0);
      @(posedge clk); #1;
      check("rbw_new_resp", m0_if.resp_valid, 1);
      check("rbw_new_rdata", m0_if.resp_rdata, 64'h9);

      // reset while an m1 response is pending
      @(negedge clk);
      drv0(1'b0, 1'b0, 12'h000, '0);
      drv1(1'b1, 1'b0, 12'h030, '0);
      @(posedge clk); #1;
      check("mrst_pending", m1_if.resp_valid, 1);
      rst = 1'b1;
      #1;
      check("mrst_m1_resp", m1_if.resp_valid, 0);
      check("mrst_m1_ready", m1_if.req_ready, 0);
      check("mrst_rd_en", sram_read_en, 0);
      @(negedge clk); #1;
      check("mrst_rd_en_hold", sram_read_en, 0);
      check("mrst_wr_en_hold", sram_wead_en, 0);
      @(negedge clk);
      rst = 1'b0;
      drv1(1'b0, 1'b0, 12'h000, '0);

      // m1 requests a write, loses, then drops it
      @(negedge clk);
      drv0(1'b1, 1'b0, 12'h020, '0);
      drv1(1'b1, 1'b1, 12'h030, 64'h7);
      #1;
      check("drop_m0_ready", m0_if.req_ready, 1);
      check("drop_m1_ready", m1_if.req_ready, 0);
      @(posedge clk); #1;
      check("drop_m0_resp", m0_if.resp_valid, 1);
      @(negedge clk);
      drv0(1'b0, 1'b0, 12'h000, '0);
      drv1(1'b0, 1'b0, 12'h000, '0);
      #1;
      check("drop_rd_en", sram_read_en, 0);
      check("drop_wr_en", sram_wead_en, 0);
      @(posedge clk); #1;
      check("drop_m1_resp", m1_if.resp_valid, 0);
      @(negedge clk);
      drv0(1'b1, 1'b0, 12'h020, '0);
      drv1(1'b1, 1'b0, 12'h030, '0);
      #1;
      check("drop_m1_next_ready", m1_if.req_ready, 1);
      @(posedge clk); #1;
      check("drop_m1_next_resp", m1_if.resp_valid, 1);
      check("drop_m1_rdata", m1_if.resp_rdata, 64'hB);
      @(negedge clk);
      drv0(1'b0, 1'b0, 12'h000, '0);
      drv1(1'b0, 1'b0, 12'h000, '0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
